// File: rtl/serial_tx_queue_if.sv
// ---------------------------------------------------------------------------
// serial_tx_queue_if: write port and status/serial signals of serial_tx_queue.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface serial_tx_queue_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) ();
  logic [DATA_W-1:0]       data;
  logic                    we;
  logic                    full;
  logic                    empty;
  logic [$clog2(DEPTH):0]  level;
  logic                    busy;
  logic                    overflow;
  logic                    tx;

  modport master (output data, we,
                  input  full, empty, level, busy, overflow, tx);
  modport slave  (input  data, we,
                  output full, empty, level, busy, overflow, tx);
endinterface

`default_nettype wire

// File: rtl/serial_tx_queue.sv
// ---------------------------------------------------------------------------
// serial_tx_queue: FIFO feeding an LSB-first serial transmitter (start/data/
// [parity]/stop). Even parity enabled by macro SERIAL_TX_PARITY_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_tx_queue #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                clk,
  input  logic                rst,
  serial_tx_queue_if.slave    bus
);

  localparam int AW       = $clog2(DEPTH);
  localparam int LW       = AW + 1;
  localparam int STOP_CYC = STOP_BITS * CLKS_PER_BIT;
  localparam int CW       = $clog2(STOP_CYC);
  localparam int BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYC - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic [LW-1:0] DEPTH_LV  = LW'(DEPTH);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD = 3'd1, START = 3'd2, DATA = 3'd3, PARITY = 3'd4, STOP = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD = 3'd1, START = 3'd2, DATA = 3'd3, STOP = 3'd5
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;
`ifdef SERIAL_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] head;
  logic              full, empty, wr_en, pop;

  assign full  = (level_q == DEPTH_LV);
  assign empty = (level_q == '0);
  assign wr_en = bus.we && !full;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head;
`ifdef SERIAL_TX_PARITY_EN
          par_d   = ^head;
`endif
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        tx_d    = 1'b0;
        state_d = START;
      end
      START: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            // Next bit is shifted into position 0; drive it one edge early
            // so tx stays a pure flop output.
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == STOP_LAST) begin
          cnt_d = '0;
          tx_d  = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = head;
`ifdef SERIAL_TX_PARITY_EN
            par_d   = ^head;
`endif
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    busy_d   = (state_d != IDLE);
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // A dropped write is judged on the pre-pop level.
    ovf_d = ovf_q | (bus.we & full);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.data;
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = level_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = ovf_q;
  assign bus.tx       = tx_q;

endmodule

`default_nettype wire
